fifo_cmd_sequencer: RTL and testbench

Command controller between the UART byte interface and the byte FIFO on the Arty7 test design. It decodes one-byte opcodes arriving on UART RX and sequences FIFO pushes and pops. It returns one response byte per command over UART TX, or a burst of bytes for READ_ALL. It is the only master of the FIFO write and read ports.

---
 rtl/fifo_cmd_pkg.sv | 27 ++
 rtl/fifo_cmd_timeout.sv | 30 +++
 rtl/fifo_cmd_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fifo_cmd_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_cmd_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART-to-FIFO command sequencer.
package fifo_cmd_pkg;

    localparam logic [7:0] OP_WRITE    = 8'h30;
    localparam logic [7:0] OP_READ     = 8'h31;
    localparam logic [7:0] OP_STATUS   = 8'h32;
    localparam logic [7:0] OP_READ_ALL = 8'h33;

    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StPop,
        StPopLat,
        StSend,
        StSendWait
    } state_e;

    // Status byte: {overrun, full, empty, occupancy[4:0]}.
    function automatic logic [7:0] status_byte(logic ovr, logic full, logic empty,
                                               logic [4:0] cnt);
        return {ovr, full, empty, cnt};
    endfunction

endpackage

// File: rtl/fifo_cmd_timeout.sv
// Loadable down-counter bounding the wait for the data byte that follows a WRITE opcode.
module fifo_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYC = 1041670
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th enabled cycle after a load.
    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/fifo_cmd_sequencer.sv
// Decodes UART opcodes, sequences FIFO pushes/pops and returns response bytes over UART TX.
module fifo_cmd_sequencer
    import fifo_cmd_pkg::*;
#(
    parameter int unsigned DEPTH       = 7,
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned TIMEOUT_CYC = 1041670
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [CNT_W-1:0] fifo_count,
    output logic             fifo_wr_en,
    output logic [7:0]       fifo_wr_data,
    output logic             fifo_rd_en,
    input  logic [7:0]       fifo_rd_data,
    output logic             overrun
);

    state_e     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_en_q, rd_en_d;
    logic       overrun_q, overrun_d;
    logic       burst_q, burst_d;
    logic       rd_pend_q, rd_pend_d;
    logic       to_load, to_en, to_expire;

    fifo_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (to_load),
        .en     (to_en),
        .expire (to_expire)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_en_d    = 1'b0;
        overrun_d  = overrun_q;
        burst_d    = burst_q;
        rd_pend_d  = rd_pend_q;
        to_load    = 1'b0;
        to_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_WRITE: begin
                            to_load = 1'b1;
                            state_d = StWaitData;
                        end
                        OP_READ: begin
                            if (fifo_empty) begin
                                tx_data_d = RSP_NAK;
                                state_d   = StSend;
                            end else begin
                                state_d = StPop;
                            end
                        end
                        OP_STATUS: begin
                            tx_data_d = status_byte(overrun_q, fifo_full, fifo_empty,
                                                    5'(fifo_count));
                            overrun_d = 1'b0;
                            state_d   = StSend;
                        end
                        OP_READ_ALL: begin
                            if (fifo_empty) begin
                                tx_data_d = RSP_NAK;
                                state_d   = StSend;
                            end else begin
                                burst_d = 1'b1;
                                state_d = StPop;
                            end
                        end
                        default: begin
                            tx_data_d = RSP_NAK;
                            state_d   = StSend;
                        end
                    endcase
                end
            end
            StWaitData: begin
                to_en = 1'b1;
                // A byte arriving on the expiry cycle still counts as the data byte.
                if (rx_valid) begin
                    if (fifo_full) begin
                        tx_data_d = RSP_NAK;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = rx_data;
                        tx_data_d = RSP_ACK;
                    end
                    state_d = StSend;
                end else if (to_expire) begin
                    tx_data_d = RSP_NAK;
                    state_d   = StSend;
                end
            end
            StPop: begin
                rd_en_d   = 1'b1;
                rd_pend_d = 1'b1;
                state_d   = StPopLat;
            end
            StPopLat: begin
                state_d = StSend;
            end
            StSend: begin
                // The strobe is registered, so popped data lands one cycle after POP_LAT.
                if (rd_pend_q) begin
                    tx_data_d = fifo_rd_data;
                    rd_pend_d = 1'b0;
                end
                tx_start_d = 1'b1;
                state_d    = StSendWait;
            end
            StSendWait: begin
                // tx_start_q marks the pulse cycle, before tx_busy has had a chance to rise.
                if (!tx_start_q && !tx_busy) begin
                    if (burst_q && !fifo_empty) begin
                        state_d = StPop;
                    end else begin
                        burst_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rx_valid && (state_q inside {StPop, StPopLat, StSend, StSendWait})) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            rd_en_q    <= 1'b0;
            overrun_q  <= 1'b0;
            burst_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            overrun_q  <= overrun_d;
            burst_q    <= burst_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Strobes are masked by rst so an aborted command never leaks a pulse.
    assign tx_start     = tx_start_q & ~rst;
    assign fifo_wr_en   = wr_en_q & ~rst;
    assign fifo_rd_en   = rd_en_q & ~rst;
    assign tx_data      = tx_data_q;
    assign fifo_wr_data = wr_data_q;
    assign overrun      = overrun_q;

    assert property (@(posedge clk) disable iff (rst) !(fifo_wr_en && fifo_rd_en));
    assert property (@(posedge clk) disable iff (rst) 32'(fifo_count) <= DEPTH);

endmodule

// File: tb/tb_fifo_cmd_sequencer.sv
// Randomised command-level bench with a queue-based FIFO/UART environment and reference model.
module tb_fifo_cmd_sequencer;

    localparam int TO    = 100;
    localparam int DEPTH = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       fifo_full, fifo_empty;
    logic [2:0] fifo_count;
    logic       fifo_wr_en, fifo_rd_en;
    logic [7:0] fifo_wr_data;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       overrun;

    fifo_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .CNT_W       (3),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: a real 7-byte FIFO driven only by the DUT strobes.
    logic [7:0] envq[$];
    int fill = 0;
    always @(posedge clk) begin
        if (fifo_rd_en && envq.size() > 0) fifo_rd_data <= envq.pop_front();
        if (fifo_wr_en && envq.size() < DEPTH) envq.push_back(fifo_wr_data);
        fill <= envq.size();
    end
    assign fifo_full  = (fill == DEPTH);
    assign fifo_empty = (fill == 0);
    assign fifo_count = fill[2:0];

    // Environment: UART TX busy for a random 2..6 cycles after each tx_start.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            busy_cnt <= $urandom_range(2, 6);
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected by the model (cycle %0d)", name, cyc);
    endtask

    // Reference model state.
    logic [7:0] mq[$];
    bit         m_ovr = 1'b0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_wr[$];
    int         exp_rd = 0;

    int         wr_cyc = -1, rd_cyc = -1, tx_cyc = -1, tx_n = 0;
    logic [7:0] last_tx = 8'h00;
    logic [7:0] held = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            chk("strobe_in_reset", {29'd0, tx_start, fifo_wr_en, fifo_rd_en}, 0);
        end else begin
            if (fifo_wr_en || fifo_rd_en) chk("wr_rd_exclusive", fifo_wr_en & fifo_rd_en, 0);
            if (fifo_wr_en) begin
                chk("wr_when_full", fifo_full, 0);
                if (exp_wr.size() == 0) fail("unexpected_wr");
                else chk("wr_data", fifo_wr_data, exp_wr.pop_front());
                if (wr_cyc < 0) wr_cyc = cyc;
            end
            if (fifo_rd_en) begin
                chk("rd_when_empty", fifo_empty, 0);
                if (exp_rd == 0) fail("unexpected_rd");
                else exp_rd--;
                if (rd_cyc < 0) rd_cyc = cyc;
            end
            if (tx_start) begin
                chk("tx_when_busy", tx_busy, 0);
                if (exp_tx.size() == 0) fail("unexpected_tx");
                else chk("tx_data", tx_data, exp_tx.pop_front());
                last_tx = tx_data;
                held    = tx_data;
                tx_n++;
                if (tx_cyc < 0) tx_cyc = cyc;
            end else if (tx_busy) begin
                chk("tx_data_hold", tx_data, held);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int at);
        rx_valid = 1'b1;
        rx_data  = b;
        at       = cyc;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_rd != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            fail("response_wait_expired");
            exp_tx.delete();
            exp_rd = 0;
        end
        n = 0;
        while (tx_busy && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("writes_done", exp_wr.size(), 0);
        exp_wr.delete();
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] data, input int gap,
                          input bit inject, input bit tmo);
        int op_at, d_at, tmp, n;
        int exp_rsp_at, exp_rd_at, exp_wr_at;
        bit popped;
        logic [7:0] st;
        exp_rd_at = -1;
        exp_wr_at = -1;
        popped    = 1'b0;
        wr_cyc = -1; rd_cyc = -1; tx_cyc = -1; tx_n = 0;
        case (op)
            8'h30: begin
                if (tmo || mq.size() == DEPTH) begin
                    exp_tx.push_back(8'h15);
                end else begin
                    mq.push_back(data);
                    exp_wr.push_back(data);
                    exp_tx.push_back(8'h06);
                end
            end
            8'h31: begin
                if (mq.size() == 0) exp_tx.push_back(8'h15);
                else begin
                    exp_tx.push_back(mq.pop_front());
                    exp_rd++;
                    popped = 1'b1;
                end
            end
            8'h32: begin
                st = {m_ovr, mq.size() == DEPTH, mq.size() == 0, 5'(mq.size())};
                m_ovr = 1'b0;
                exp_tx.push_back(st);
            end
            8'h33: begin
                if (mq.size() == 0) exp_tx.push_back(8'h15);
                else begin
                    popped = 1'b1;
                    while (mq.size() > 0) begin
                        exp_tx.push_back(mq.pop_front());
                        exp_rd++;
                    end
                end
            end
            default: exp_tx.push_back(8'h15);
        endcase

        send_byte(op, op_at);
        if (op == 8'h30) begin
            if (tmo) begin
                exp_rsp_at = op_at + TO + 2;
            end else begin
                repeat (gap) tick();
                send_byte(data, d_at);
                exp_rsp_at = d_at + 2;
                if (exp_wr.size() != 0) exp_wr_at = d_at + 1;
            end
        end else if (popped) begin
            exp_rd_at  = op_at + 2;
            exp_rsp_at = op_at + 4;
        end else begin
            exp_rsp_at = op_at + 2;
        end

        if (inject) begin
            n = 0;
            while (!tx_busy && n < 3000) begin
                tick();
                n++;
            end
            if (tx_busy) begin
                send_byte(8'($urandom), tmp);
                m_ovr = 1'b1;
            end else begin
                fail("inject_wait_expired");
            end
        end

        wait_done();
        chk("rsp_latency", tx_cyc, exp_rsp_at);
        chk("rd_latency", rd_cyc, exp_rd_at);
        chk("wr_latency", wr_cyc, exp_wr_at);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        tick();
        chk("rst_tx_data", tx_data, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_strobes", {29'd0, tx_start, fifo_wr_en, fifo_rd_en}, 0);
        rst = 1'b0;
        tick();
        m_ovr = 1'b0;
        exp_tx.delete();
        exp_rd = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, r;
        logic [7:0] b;
        repeat (2) tick();
        apply_reset();

        // Basic write then reads, including read-from-empty.
        do_cmd(8'h30, 8'hAA, 0, 0, 0);
        chk("lit_write_ack", last_tx, 8'h06);
        chk("lit_write_ntx", tx_n, 1);
        do_cmd(8'h30, 8'h31, 1, 0, 0);
        do_cmd(8'h31, 8'h00, 0, 0, 0);
        chk("lit_read_aa", last_tx, 8'hAA);
        do_cmd(8'h31, 8'h00, 0, 0, 0);
        do_cmd(8'h31, 8'h00, 0, 0, 0);
        chk("lit_read_empty_nak", last_tx, 8'h15);

        // Fill to full, write into full FIFO, drain with READ_ALL.
        for (int i = 0; i < DEPTH; i++) do_cmd(8'h30, 8'(8'h40 + i), i % 3, 0, 0);
        do_cmd(8'h30, 8'hBB, 0, 0, 0);
        chk("lit_full_nak", last_tx, 8'h15);
        do_cmd(8'h33, 8'h00, 0, 0, 0);
        chk("lit_drain_ntx", tx_n, 7);
        chk("lit_drain_last", last_tx, 8'h46);

        // Data-byte timeout, then an opcode decoded normally.
        do_cmd(8'h30, 8'h00, 0, 0, 1);
        chk("lit_timeout_nak", last_tx, 8'h15);
        do_cmd(8'h32, 8'h00, 0, 0, 0);
        chk("lit_status_empty", last_tx, 8'h20);

        // Data byte arriving on the expiry cycle wins.
        do_cmd(8'h30, 8'h5A, TO - 1, 0, 0);
        chk("lit_edge_ack", last_tx, 8'h06);
        do_cmd(8'h31, 8'h00, 0, 0, 0);
        chk("lit_edge_data", last_tx, 8'h5A);

        // Burst of three.
        do_cmd(8'h30, 8'h10, 0, 0, 0);
        do_cmd(8'h30, 8'h11, 0, 0, 0);
        do_cmd(8'h30, 8'h12, 0, 0, 0);
        do_cmd(8'h33, 8'h00, 0, 0, 0);
        chk("lit_burst_ntx", tx_n, 3);
        chk("lit_burst_last", last_tx, 8'h12);

        // Overrun while busy, then STATUS reports and clears it.
        for (int i = 0; i < 4; i++) do_cmd(8'h30, 8'(8'h70 + i), 0, 0, 0);
        do_cmd(8'h31, 8'h00, 0, 1, 0);
        chk("lit_overrun_set", overrun, 1);
        do_cmd(8'h32, 8'h00, 0, 0, 0);
        chk("lit_status_83", last_tx, 8'h83);
        chk("lit_overrun_clr", overrun, 0);

        // Reset in the tx_start cycle of a WRITE: push already done, no response.
        wr_cyc = -1; tx_n = 0;
        mq.push_back(8'hC3);
        exp_wr.push_back(8'hC3);
        send_byte(8'h30, at);
        send_byte(8'hC3, at);
        tick();
        apply_reset();
        chk("rst_write_pushed", wr_cyc, at + 1);
        chk("rst_write_no_tx", tx_n, 0);

        // Reset while in POP: no pop, no response.
        rd_cyc = -1; tx_n = 0;
        send_byte(8'h31, at);
        apply_reset();
        repeat (4) tick();
        chk("rst_pop_no_rd", rd_cyc, -1);
        chk("rst_pop_no_tx", tx_n, 0);

        // Randomised traffic.
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40) do_cmd(8'h30, 8'($urandom), $urandom_range(0, 3),
                               $urandom_range(0, 9) == 0, 0);
            else if (r < 58) do_cmd(8'h31, 8'h00, 0, $urandom_range(0, 9) == 0, 0);
            else if (r < 66) do_cmd(8'h33, 8'h00, 0, $urandom_range(0, 9) == 0, 0);
            else if (r < 78) do_cmd(8'h32, 8'h00, 0, $urandom_range(0, 9) == 0, 0);
            else if (r < 88) begin
                b = 8'($urandom);
                if (b inside {[8'h30:8'h33]}) b = b ^ 8'h80;
                do_cmd(b, 8'h00, 0, $urandom_range(0, 9) == 0, 0);
            end else if (r < 98) do_cmd(8'h30, 8'($urandom), 0, 0, 0);
            else do_cmd(8'h30, 8'h00, 0, 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
